// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter and command sequencer for a single-port 8-bit x 256 RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of burst-limited round-robin.
module ram_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,

    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,

    output logic       ram_wr_en,
    output logic       ram_rd_en,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    localparam logic       REQ_A       = 1'b0;
    localparam logic       REQ_B       = 1'b1;

    state_t     state;
    logic [3:0] burst_cnt;
    logic       rr_last;
    logic       grant_a;
    logic       grant_b;

    logic       rd_valid_1;
    logic       rd_owner_1;
    logic       rd_valid_2;
    logic       rd_owner_2;
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_a = rst & a_req;
        grant_b = rst & b_req & ~a_req;
    end
`else
    // The current owner keeps the port until it drops req or exhausts its burst while the other waits.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (a_req && b_req) begin
                        if (rr_last == REQ_B) grant_a = 1'b1;
                        else                  grant_b = 1'b1;
                    end else begin
                        grant_a = a_req;
                        grant_b = b_req;
                    end
                end
                OWN_A: begin
                    if (a_req && (!b_req || burst_cnt < BURST_LIMIT)) grant_a = 1'b1;
                    else if (b_req)                                   grant_b = 1'b1;
                end
                OWN_B: begin
                    if (b_req && (!a_req || burst_cnt < BURST_LIMIT)) grant_b = 1'b1;
                    else if (a_req)                                   grant_a = 1'b1;
                end
                default: begin
                    grant_a = 1'b0;
                    grant_b = 1'b0;
                end
            endcase
        end
    end
`endif

    assign a_gnt = grant_a;
    assign b_gnt = grant_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
            rr_last   <= REQ_B;
        end else if (grant_a) begin
            state   <= OWN_A;
            rr_last <= REQ_A;
            if (state != OWN_A)              burst_cnt <= 4'd1;
            else if (burst_cnt < BURST_LIMIT) burst_cnt <= burst_cnt + 4'd1;
        end else if (grant_b) begin
            state   <= OWN_B;
            rr_last <= REQ_B;
            if (state != OWN_B)              burst_cnt <= 4'd1;
            else if (burst_cnt < BURST_LIMIT) burst_cnt <= burst_cnt + 4'd1;
        end else begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end
    end

    // Address and write data keep their last value when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_wr_en <= 1'b0;
            ram_rd_en <= 1'b0;
            ram_addr  <= 8'd0;
            ram_wdata <= 8'd0;
        end else if (grant_a) begin
            ram_wr_en <= a_we;
            ram_rd_en <= ~a_we;
            ram_addr  <= a_addr;
            ram_wdata <= a_wdata;
        end else if (grant_b) begin
            ram_wr_en <= b_we;
            ram_rd_en <= ~b_we;
            ram_addr  <= b_addr;
            ram_wdata <= b_wdata;
        end else begin
            ram_wr_en <= 1'b0;
            ram_rd_en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_1 <= 1'b0;
            rd_owner_1 <= REQ_A;
            rd_valid_2 <= 1'b0;
            rd_owner_2 <= REQ_A;
        end else begin
            rd_valid_1 <= (grant_a & ~a_we) | (grant_b & ~b_we);
            rd_owner_1 <= grant_b ? REQ_B : REQ_A;
            rd_valid_2 <= rd_valid_1;
            rd_owner_2 <= rd_owner_1;
        end
    end

    assign a_rvalid = rd_valid_2 & (rd_owner_2 == REQ_A);
    assign b_rvalid = rd_valid_2 & (rd_owner_2 == REQ_B);

    // RAM data passes straight through in the return cycle and is held afterwards.
    assign a_rdata = a_rvalid ? ram_rdata : a_rdata_q;
    assign b_rdata = b_rvalid ? ram_rdata : b_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_rdata_q <= 8'd0;
            b_rdata_q <= 8'd0;
        end else begin
            a_rdata_q <= a_rdata;
            b_rdata_q <= b_rdata;
        end
    end

endmodule
